// File: rtl/etc_pkg.sv
// Shared types and defaults for the tile drain block.
package etc_pkg;

  localparam int W_DEFAULT = 16;
  localparam int N_DEFAULT = 4;

  typedef logic [W_DEFAULT-1:0] elem_t;
  typedef elem_t [N_DEFAULT-1:0][N_DEFAULT-1:0] tile_t;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } drain_state_e;

endpackage

// File: rtl/etc_tile_drain_if.sv
// Capture-side and stream-side signals of the tile drain block.
interface etc_tile_drain_if
  import etc_pkg::*;
#(
  parameter int W = W_DEFAULT,
  parameter int N = N_DEFAULT
);

  localparam int IW = $clog2(N);

  logic                        cap_valid_i;
  logic                        cap_ready_o;
  logic [N-1:0][N-1:0][W-1:0]  tile_i;
  logic                        col_major_i;
  logic                        out_valid_o;
  logic                        out_ready_i;
  logic [W-1:0]                out_data_o;
  logic [IW-1:0]               out_row_o;
  logic [IW-1:0]               out_col_o;
  logic                        out_last_o;

  modport slave (
    input  cap_valid_i, tile_i, col_major_i, out_ready_i,
    output cap_ready_o, out_valid_o, out_data_o, out_row_o, out_col_o, out_last_o
  );

  modport master (
    output cap_valid_i, tile_i, col_major_i, out_ready_i,
    input  cap_ready_o, out_valid_o, out_data_o, out_row_o, out_col_o, out_last_o
  );

endinterface

// File: rtl/etc_tile_buf.sv
// One stored tile plus its drain-order bit, with an element read port.
module etc_tile_buf
  import etc_pkg::*;
#(
  parameter int W = W_DEFAULT,
  parameter int N = N_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       load,
  input  logic [N-1:0][N-1:0][W-1:0] tile_d,
  input  logic                       order_d,
  input  logic [$clog2(N)-1:0]       row,
  input  logic [$clog2(N)-1:0]       col,
  output logic [W-1:0]               elem,
  output logic                       col_major
);

  logic [N-1:0][N-1:0][W-1:0] tile_q;

  // Latch the tile and its order bit together when loaded
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tile_q    <= '0;
      col_major <= 1'b0;
    end else if (load) begin
      tile_q    <= tile_d;
      col_major <= order_d;
    end
  end

  assign elem = tile_q[row][col];

endmodule

// File: rtl/etc_tile_drain.sv
// Ping-pong tile capture and per-element serialiser.
//   state | meaning
//   IDLE  | no tile being drained, out_valid_o low
//   DRAIN | presenting element idx of buf[rd_sel]
module etc_tile_drain
  import etc_pkg::*;
#(
  parameter int W = W_DEFAULT,
  parameter int N = N_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  etc_tile_drain_if.slave bus,
  output logic            busy_o
);

  localparam int IW = $clog2(N);
  localparam int NN = N * N;
  localparam int XW = 2 * IW;
  localparam logic [XW-1:0] IDX_LAST = XW'(NN - 1);

  drain_state_e  state_q, state_d;
  logic [1:0]    full_q;
  logic          rd_sel_q, wr_sel_q;
  logic [XW-1:0] idx_q;

  logic          cap_ready, cap_fire, drain, beat_fire, is_last, last_fire;
  logic          cm0, cm1, rd_cm;
  logic [IW-1:0] rd_row, rd_col;
  logic [W-1:0]  elem0, elem1;

  assign cap_ready = ~(full_q[0] & full_q[1]);
  assign cap_fire  = bus.cap_valid_i & cap_ready;
  assign drain     = (state_q == DRAIN);
  assign beat_fire = drain & bus.out_ready_i;
  assign is_last   = (idx_q == IDX_LAST);
  assign last_fire = beat_fire & is_last;

  // N is a power of two, so idx/N and idx%N are just the high and low halves
  assign rd_cm  = rd_sel_q ? cm1 : cm0;
  assign rd_row = rd_cm ? idx_q[IW-1:0] : idx_q[XW-1:IW];
  assign rd_col = rd_cm ? idx_q[XW-1:IW] : idx_q[IW-1:0];

  etc_tile_buf #(.W(W), .N(N)) u_buf0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (cap_fire & ~wr_sel_q),
    .tile_d    (bus.tile_i),
    .order_d   (bus.col_major_i),
    .row       (rd_row),
    .col       (rd_col),
    .elem      (elem0),
    .col_major (cm0)
  );

  etc_tile_buf #(.W(W), .N(N)) u_buf1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (cap_fire & wr_sel_q),
    .tile_d    (bus.tile_i),
    .order_d   (bus.col_major_i),
    .row       (rd_row),
    .col       (rd_col),
    .elem      (elem1),
    .col_major (cm1)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state: a capture straight into the read buffer starts draining on the next cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (full_q[rd_sel_q] | (cap_fire & (wr_sel_q == rd_sel_q))) state_d = DRAIN;
      DRAIN: if (last_fire & ~full_q[~rd_sel_q]) state_d = IDLE;
    endcase
  end

  // Buffer occupancy, pointers and element index; capture and drain never hit the same buffer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q   <= 2'b00;
      rd_sel_q <= 1'b0;
      wr_sel_q <= 1'b0;
      idx_q    <= '0;
    end else begin
      if (cap_fire) begin
        full_q[wr_sel_q] <= 1'b1;
        wr_sel_q         <= ~wr_sel_q;
      end
      if (last_fire) begin
        full_q[rd_sel_q] <= 1'b0;
        rd_sel_q         <= ~rd_sel_q;
        idx_q            <= '0;
      end else if (beat_fire) begin
        idx_q <= idx_q + XW'(1);
      end
    end
  end

  // Stream outputs come only from stored state, so they hold steady while stalled
  always_comb begin
    bus.out_valid_o = 1'b0;
    bus.out_data_o  = '0;
    bus.out_row_o   = '0;
    bus.out_col_o   = '0;
    bus.out_last_o  = 1'b0;
    if (drain) begin
      bus.out_valid_o = 1'b1;
      bus.out_data_o  = rd_sel_q ? elem1 : elem0;
      bus.out_row_o   = rd_row;
      bus.out_col_o   = rd_col;
      bus.out_last_o  = is_last;
    end
  end

  assign bus.cap_ready_o = cap_ready;
  assign busy_o          = full_q[0] | full_q[1];

endmodule

// File: tb/tb_etc_tile_drain.sv
// Self-checking bench for etc_tile_drain against a queue-of-beats model.
module tb_etc_tile_drain;
  import etc_pkg::*;

  localparam int W  = W_DEFAULT;
  localparam int N  = N_DEFAULT;
  localparam int NN = N * N;
  localparam int IW = $clog2(N);

  typedef struct {
    logic [W-1:0]  data;
    logic [IW-1:0] row;
    logic [IW-1:0] col;
    logic          last;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;

  etc_tile_drain_if #(.W(W), .N(N)) bus ();

  etc_tile_drain #(.W(W), .N(N)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus    (bus),
    .busy_o (busy)
  );

  always #5 clk = ~clk;

  beat_t exp_q[$];
  int checks = 0;
  int errors = 0;

  // Model: a captured tile expands to its N*N beats in the order chosen at capture
  task automatic model_capture(input tile_t t, input bit cm);
    for (int k = 0; k < NN; k++) begin
      beat_t b;
      int r, c;
      if (cm) begin r = k % N; c = k / N; end
      else    begin r = k / N; c = k % N; end
      b.data = t[r][c];
      b.row  = IW'(r);
      b.col  = IW'(c);
      b.last = (k == NN - 1);
      exp_q.push_back(b);
    end
  endtask

  function automatic int tiles_held();
    return (exp_q.size() + NN - 1) / NN;
  endfunction

  function automatic tile_t ramp_tile();
    tile_t t;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        t[r][c] = W'(16 * r + c);
    return t;
  endfunction

  function automatic tile_t fill_tile(input logic [W-1:0] v);
    tile_t t;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        t[r][c] = v;
    return t;
  endfunction

  function automatic tile_t rand_tile();
    tile_t t;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        t[r][c] = W'($urandom);
    return t;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if ({bus.cap_ready_o, bus.out_valid_o, bus.out_data_o, bus.out_row_o, bus.out_col_o,
         bus.out_last_o, busy} !== {1'b1, 1'b0, {W{1'b0}}, {IW{1'b0}}, {IW{1'b0}}, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_values: ready=%b valid=%b data=%h row=%0d col=%0d last=%b busy=%b, want ready=1 rest 0",
               bus.cap_ready_o, bus.out_valid_o, bus.out_data_o, bus.out_row_o, bus.out_col_o,
               bus.out_last_o, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (bus.cap_ready_o !== 1'b1 || bus.out_valid_o !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL idle_after_reset cyc %0d: ready=%b valid=%b busy=%b, want 1 0 0",
                 i, bus.cap_ready_o, bus.out_valid_o, busy);
      end
    end
  endtask

  task automatic test_single_tile(input bit cm);
    beat_t e;
    exp_q.delete();
    bus.tile_i      = ramp_tile();
    bus.col_major_i = cm;
    bus.cap_valid_i = 1'b1;
    bus.out_ready_i = 1'b1;
    checks++;
    if (bus.cap_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL order%0d_cap_ready: got %b want 1", cm, bus.cap_ready_o);
    end
    model_capture(ramp_tile(), cm);
    tick();
    bus.cap_valid_i = 1'b0;
    bus.col_major_i = ~cm;
    bus.tile_i      = '0;
    for (int k = 0; k < NN; k++) begin
      e = exp_q.pop_front();
      checks++;
      if (bus.out_valid_o !== 1'b1 || bus.out_data_o !== e.data || bus.out_row_o !== e.row ||
          bus.out_col_o !== e.col || bus.out_last_o !== e.last) begin
        errors++;
        $display("FAIL order%0d_beat %0d: v=%b d=%h r=%0d c=%0d l=%b, want v=1 d=%h r=%0d c=%0d l=%b",
                 cm, k, bus.out_valid_o, bus.out_data_o, bus.out_row_o, bus.out_col_o,
                 bus.out_last_o, e.data, e.row, e.col, e.last);
      end
      tick();
    end
    checks++;
    if (bus.out_valid_o !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL order%0d_done: valid=%b busy=%b want 0 0", cm, bus.out_valid_o, busy);
    end
  endtask

  task automatic test_back_to_back();
    beat_t e;
    bit    exp_ready;
    exp_q.delete();
    bus.tile_i      = fill_tile(W'(16'h1111));
    bus.col_major_i = 1'b0;
    bus.cap_valid_i = 1'b1;
    bus.out_ready_i = 1'b1;
    checks++;
    if (bus.out_valid_o !== 1'b0 || bus.cap_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL b2b_start: valid=%b ready=%b want 0 1", bus.out_valid_o, bus.cap_ready_o);
    end
    model_capture(fill_tile(W'(16'h1111)), 1'b0);
    tick();
    for (int k = 0; k < 2 * NN; k++) begin
      bus.cap_valid_i = (k == 0);
      bus.tile_i      = fill_tile(W'(16'h2222));
      exp_ready = (tiles_held() < 2);
      e = exp_q.pop_front();
      checks++;
      if (bus.out_valid_o !== 1'b1 || bus.out_data_o !== e.data || bus.out_last_o !== e.last ||
          bus.cap_ready_o !== exp_ready) begin
        errors++;
        $display("FAIL b2b_beat %0d: v=%b d=%h l=%b rdy=%b, want v=1 d=%h l=%b rdy=%b",
                 k, bus.out_valid_o, bus.out_data_o, bus.out_last_o, bus.cap_ready_o,
                 e.data, e.last, exp_ready);
      end
      if (k == 0) model_capture(fill_tile(W'(16'h2222)), 1'b0);
      tick();
    end
    bus.cap_valid_i = 1'b0;
    checks++;
    if (bus.out_valid_o !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_done: valid=%b busy=%b want 0 0", bus.out_valid_o, busy);
    end
  endtask

  task automatic test_backpressure();
    beat_t e;
    logic [W+2*IW:0] snap;
    bit   stalled;
    int   budget;
    exp_q.delete();
    bus.tile_i      = ramp_tile();
    bus.col_major_i = 1'b0;
    bus.cap_valid_i = 1'b1;
    bus.out_ready_i = 1'b0;
    model_capture(ramp_tile(), 1'b0);
    tick();
    bus.cap_valid_i = 1'b0;
    stalled = 1'b0;
    snap    = '0;
    budget  = 0;
    while (exp_q.size() > 0 && budget < 300) begin
      budget++;
      bus.out_ready_i = 1'($urandom_range(0, 1));
      e = exp_q[0];
      checks++;
      if (bus.out_valid_o !== 1'b1 || bus.out_data_o !== e.data || bus.out_row_o !== e.row ||
          bus.out_col_o !== e.col || bus.out_last_o !== e.last) begin
        errors++;
        $display("FAIL bp_beat: v=%b d=%h r=%0d c=%0d l=%b, want v=1 d=%h r=%0d c=%0d l=%b",
                 bus.out_valid_o, bus.out_data_o, bus.out_row_o, bus.out_col_o,
                 bus.out_last_o, e.data, e.row, e.col, e.last);
      end
      if (stalled) begin
        checks++;
        if ({bus.out_data_o, bus.out_row_o, bus.out_col_o, bus.out_last_o} !== snap) begin
          errors++;
          $display("FAIL bp_hold: got %h want %h",
                   {bus.out_data_o, bus.out_row_o, bus.out_col_o, bus.out_last_o}, snap);
        end
      end
      snap    = {bus.out_data_o, bus.out_row_o, bus.out_col_o, bus.out_last_o};
      stalled = !bus.out_ready_i;
      if (bus.out_ready_i) void'(exp_q.pop_front());
      tick();
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL bp_timeout: %0d beats left, want 0", exp_q.size());
    end
    bus.out_ready_i = 1'b1;
  endtask

  task automatic test_random();
    bit    bubble, exp_valid, exp_ready, cap_fire, out_fire, last_fire;
    int    tiles;
    tile_t t;
    bit    cm;
    exp_q.delete();
    bubble = 1'b0;
    for (int i = 0; i < 600; i++) begin
      t  = rand_tile();
      cm = 1'($urandom_range(0, 1));
      bus.tile_i      = t;
      bus.col_major_i = cm;
      bus.cap_valid_i = (i < 550) ? ($urandom_range(0, 99) < 20) : 1'b0;
      bus.out_ready_i = (i < 550) ? ($urandom_range(0, 99) < 60) : 1'b1;
      tiles     = tiles_held();
      exp_ready = (tiles < 2);
      exp_valid = (tiles > 0) && !bubble;
      checks++;
      if (bus.cap_ready_o !== exp_ready || busy !== (tiles > 0) || bus.out_valid_o !== exp_valid) begin
        errors++;
        $display("FAIL rand_ctrl cyc %0d: rdy=%b busy=%b v=%b, want rdy=%b busy=%b v=%b",
                 i, bus.cap_ready_o, busy, bus.out_valid_o, exp_ready, tiles > 0, exp_valid);
      end
      if (exp_valid) begin
        checks++;
        if (bus.out_data_o !== exp_q[0].data || bus.out_row_o !== exp_q[0].row ||
            bus.out_col_o !== exp_q[0].col || bus.out_last_o !== exp_q[0].last) begin
          errors++;
          $display("FAIL rand_beat cyc %0d: d=%h r=%0d c=%0d l=%b, want d=%h r=%0d c=%0d l=%b",
                   i, bus.out_data_o, bus.out_row_o, bus.out_col_o, bus.out_last_o,
                   exp_q[0].data, exp_q[0].row, exp_q[0].col, exp_q[0].last);
        end
      end
      out_fire  = exp_valid && bus.out_ready_i;
      last_fire = out_fire && exp_q[0].last;
      cap_fire  = bus.cap_valid_i && exp_ready;
      // A tile finishing while the only other tile is still arriving leaves one idle cycle
      bubble    = last_fire && cap_fire && (tiles == 1);
      if (out_fire) void'(exp_q.pop_front());
      if (cap_fire) model_capture(t, cm);
      tick();
    end
    bus.cap_valid_i = 1'b0;
    checks++;
    if (exp_q.size() != 0 || busy !== 1'b0 || bus.out_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL rand_drained: left=%0d busy=%b v=%b, want 0 0 0", exp_q.size(), busy, bus.out_valid_o);
    end
  endtask

  task automatic test_reset_mid_drain();
    beat_t e;
    exp_q.delete();
    bus.tile_i      = ramp_tile();
    bus.col_major_i = 1'b0;
    bus.cap_valid_i = 1'b1;
    bus.out_ready_i = 1'b1;
    model_capture(ramp_tile(), 1'b0);
    tick();
    bus.cap_valid_i = 1'b0;
    for (int k = 0; k < 5; k++) begin
      e = exp_q.pop_front();
      checks++;
      if (bus.out_valid_o !== 1'b1 || bus.out_data_o !== e.data) begin
        errors++;
        $display("FAIL rmd_pre %0d: v=%b d=%h want v=1 d=%h", k, bus.out_valid_o, bus.out_data_o, e.data);
      end
      tick();
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.cap_ready_o, bus.out_valid_o, bus.out_data_o, bus.out_row_o, bus.out_col_o,
         bus.out_last_o, busy} !== {1'b1, 1'b0, {W{1'b0}}, {IW{1'b0}}, {IW{1'b0}}, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL rmd_reset: ready=%b valid=%b data=%h row=%0d col=%0d last=%b busy=%b, want ready=1 rest 0",
               bus.cap_ready_o, bus.out_valid_o, bus.out_data_o, bus.out_row_o, bus.out_col_o,
               bus.out_last_o, busy);
    end
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (bus.out_valid_o !== 1'b0 || busy !== 1'b0 || bus.cap_ready_o !== 1'b1) begin
        errors++;
        $display("FAIL rmd_quiet cyc %0d: v=%b busy=%b rdy=%b, want 0 0 1",
                 i, bus.out_valid_o, busy, bus.cap_ready_o);
      end
    end
    bus.tile_i      = fill_tile(W'(16'h0abc));
    bus.col_major_i = 1'b1;
    bus.cap_valid_i = 1'b1;
    model_capture(fill_tile(W'(16'h0abc)), 1'b1);
    tick();
    bus.cap_valid_i = 1'b0;
    for (int k = 0; k < NN; k++) begin
      e = exp_q.pop_front();
      checks++;
      if (bus.out_valid_o !== 1'b1 || bus.out_data_o !== e.data || bus.out_row_o !== e.row ||
          bus.out_col_o !== e.col || bus.out_last_o !== e.last) begin
        errors++;
        $display("FAIL rmd_new_beat %0d: v=%b d=%h r=%0d c=%0d l=%b, want v=1 d=%h r=%0d c=%0d l=%b",
                 k, bus.out_valid_o, bus.out_data_o, bus.out_row_o, bus.out_col_o,
                 bus.out_last_o, e.data, e.row, e.col, e.last);
      end
      tick();
    end
  endtask

  initial begin
    bus.cap_valid_i = 1'b0;
    bus.tile_i      = '0;
    bus.col_major_i = 1'b0;
    bus.out_ready_i = 1'b0;
    test_reset();
    test_single_tile(1'b0);
    test_single_tile(1'b1);
    test_back_to_back();
    test_backpressure();
    test_random();
    test_reset_mid_drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
